// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: PC generation, single-outstanding imem handshake, IF/ID register and skid buffer.
// Define IF_STALL_COUNT_EN to add the StallCount output (cycles a valid instruction sat stalled).
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic [31:0] Inst,
  output logic [31:0] InstPc,
  output logic        InstValid
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [31:0] StallCount
`endif
);

  // state   | meaning
  // S_FETCH | request at pc may issue (blocked while skid buffer is full)
  // S_WAIT  | one request outstanding, response will be delivered
  // S_DRAIN | outstanding request was flushed by redirect, next response is discarded
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic        skid_valid, skid_valid_nxt;
  logic [31:0] skid_data, skid_data_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic        inst_valid_nxt;
  logic        resp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_data  <= NOP_INST;
      skid_pc    <= RESET_PC;
      Inst       <= NOP_INST;
      InstPc     <= RESET_PC;
      InstValid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_pc     <= req_pc_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_pc    <= skid_pc_nxt;
      Inst       <= inst_nxt;
      InstPc     <= inst_pc_nxt;
      InstValid  <= inst_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_pc_nxt     = req_pc;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_pc_nxt    = skid_pc;
    inst_nxt       = Inst;
    inst_pc_nxt    = InstPc;
    inst_valid_nxt = InstValid;
    ImemReq        = 1'b0;
    ImemAddr       = pc;
    resp           = 1'b0;

    if (Redirect) begin
      pc_nxt         = RedirectPc;
      inst_valid_nxt = 1'b0;
      inst_nxt       = NOP_INST;
      skid_valid_nxt = 1'b0;
      if (state == S_WAIT)
        state_nxt = ImemRvalid ? S_FETCH : S_DRAIN;
    end else begin
      case (state)
        S_FETCH: begin
          // Holding off while the skid is full keeps skid and a new response from ever coexisting.
          ImemReq = !skid_valid && !Reset;
          if (ImemReq && ImemGnt) begin
            pc_nxt     = pc + 32'd4;
            req_pc_nxt = pc;
            state_nxt  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ImemRvalid) begin
            resp      = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (ImemRvalid) state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase

      if (InstValid && !Stall) begin
        if (skid_valid) begin
          inst_nxt       = skid_data;
          inst_pc_nxt    = skid_pc;
          skid_valid_nxt = 1'b0;
        end else if (resp) begin
          inst_nxt    = ImemRdata;
          inst_pc_nxt = req_pc;
        end else begin
          inst_valid_nxt = 1'b0;
          inst_nxt       = NOP_INST;
        end
      end else if (resp) begin
        if (!InstValid) begin
          inst_nxt       = ImemRdata;
          inst_pc_nxt    = req_pc;
          inst_valid_nxt = 1'b1;
        end else begin
          skid_valid_nxt = 1'b1;
          skid_data_nxt  = ImemRdata;
          skid_pc_nxt    = req_pc;
        end
      end
    end
  end

`ifdef IF_STALL_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      StallCount <= '0;
    else if (InstValid && Stall && !Redirect)
      StallCount <= StallCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: reactive memory model, expected words queued at response time.
module tb_inst_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic [31:0] Inst;
  logic [31:0] InstPc;
  logic        InstValid;
`ifdef IF_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  inst_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .Clk(Clk), .Reset(Reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
    .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .Stall(Stall), .Redirect(Redirect), .RedirectPc(RedirectPc),
    .Inst(Inst), .InstPc(InstPc), .InstValid(InstValid)
`ifdef IF_STALL_COUNT_EN
    , .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        pend = 1'b0;
  logic        pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_pc = '0;
  logic [31:0] exp_pc = RESET_PC;
  int          lat = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'hfd010113;
      32'h4:   mem = 32'h02812623;
      32'h8:   mem = 32'h00f71863;
      32'hc:   mem = 32'h0000b7b7;
      32'h10:  mem = 32'h00c0006f;
      default: mem = (a << 5) | 32'h13;
    endcase
  endfunction

  // One clock cycle: drive inputs after negedge, compare outputs, advance the model.
  task automatic tick(input logic stall, input logic redir, input logic [31:0] rpc, input logic gnt);
    logic rv;
    logic exp_req;
    logic consume;
    @(negedge Clk);
    rv = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) rv = 1'b1;
    end
    Stall = stall; Redirect = redir; RedirectPc = rpc; ImemGnt = gnt;
    ImemRvalid = rv;
    ImemRdata = rv ? mem(pend_pc) : 32'hdeadbeef;
    #1;
    if (q.size() > 0) begin
      chk("valid", 32'(InstValid), 32'd1);
      chk("inst", Inst, q[0].inst);
      chk("inst_pc", InstPc, q[0].pc);
    end else begin
      chk("valid", 32'(InstValid), 32'd0);
      chk("nop", Inst, NOP_INST);
    end
    exp_req = !pend && (q.size() < 2) && !redir;
    chk("req", 32'(ImemReq), 32'(exp_req));
    consume = (q.size() > 0) && !stall && !redir;
    if (consume) void'(q.pop_front());
    if (rv) begin
      if (!pend_stale && !redir) q.push_back('{pc: pend_pc, inst: mem(pend_pc)});
      pend = 1'b0;
      pend_stale = 1'b0;
    end
    if (redir) begin
      q.delete();
      if (pend) pend_stale = 1'b1;
      exp_pc = rpc;
    end
    if (exp_req && gnt) begin
      chk("addr", ImemAddr, exp_pc);
      pend = 1'b1; pend_cnt = lat; pend_pc = exp_pc; pend_stale = 1'b0;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic reset_mid();
    @(posedge Clk);
    #2;
    Reset = 1'b1; ImemRvalid = 1'b0; ImemGnt = 1'b0; Redirect = 1'b0; Stall = 1'b0;
    #1;
    chk("rst_req", 32'(ImemReq), 32'd0);
    chk("rst_valid", 32'(InstValid), 32'd0);
    chk("rst_addr", ImemAddr, RESET_PC);
    chk("rst_inst", Inst, NOP_INST);
`ifdef IF_STALL_COUNT_EN
    chk("rst_stall_cnt", StallCount, 32'd0);
`endif
    q.delete(); pend = 1'b0; pend_stale = 1'b0; exp_pc = RESET_PC;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
    Stall = 1'b0; Redirect = 1'b0; RedirectPc = '0;
    #1;
    chk("init_valid", 32'(InstValid), 32'd0);
    chk("init_inst", Inst, NOP_INST);
    chk("init_pc", InstPc, RESET_PC);
    chk("init_req", 32'(ImemReq), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Back-to-back fetch with 1-cycle memory: 0x0, 0x4, 0x8.
    lat = 1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, '0, 1'b1);
    // 0x8 held under stall while 0xc arrives into the skid.
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("held_inst", Inst, 32'h00f71863);
    tick(1'b1, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("skid_full_noreq", 32'(ImemReq), 32'd0);
    tick(1'b0, 1'b0, '0, 1'b1);
    lat = 3;
    tick(1'b0, 1'b0, '0, 1'b1);
    chk("skid_out", Inst, 32'h0000b7b7);

    // Redirect while waiting on 0x10; stale word lands two cycles later.
    chk("wait_0x10", 32'(pend), 32'd1);
    tick(1'b0, 1'b1, 32'h100, 1'b1);
    lat = 1;
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, '0, 1'b1);
      chk("stale_absent", 32'(Inst == 32'h00c0006f), 32'd0);
    end

    // Redirect coinciding with the response.
    for (int i = 0; i < 8 && !(pend && pend_cnt == 1); i++) tick(1'b0, 1'b0, '0, 1'b1);
    chk("pre_rv_redirect", 32'(pend), 32'd1);
    tick(1'b0, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, 1'b1);

    // Redirect while stalled with a valid instruction held.
    for (int i = 0; i < 8 && q.size() == 0; i++) tick(1'b0, 1'b0, '0, 1'b1);
    chk("pre_stall_redirect", 32'(q.size()), 32'd1);
    tick(1'b1, 1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0, 1'b1);

    // Reset while a request is outstanding.
    lat = 2;
    for (int i = 0; i < 8 && !(pend && pend_cnt == lat); i++) tick(1'b0, 1'b0, '0, 1'b1);
    chk("pre_reset_wait", 32'(pend), 32'd1);
    reset_mid();
    lat = 1;
    for (int i = 0; i < 8 && q.size() == 0; i++) tick(1'b0, 1'b0, '0, 1'b1);
    chk("post_reset_valid", 32'(q.size()), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
`ifdef IF_STALL_COUNT_EN
    chk("stall_cnt", StallCount, 32'd5);
`endif
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, '0, 1'b0);
    chk("sb_empty", 32'(q.size()), 32'd0);
    reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
